// File: rtl/bram_lane_accessor.sv
`default_nettype none
// ============================================================================
// Module   : bram_lane_accessor
// Purpose  : Streams words from BRAM0, zero/sign-extends or accumulates each
//            lane, and writes one result word per source word to BRAM1.
// Option   : define BRAM_ACC_SATURATE_EN to clamp mode-2 accumulators.
// Revision : 1.0 - initial parametrised lane accessor
// ============================================================================
module bram_lane_accessor #(
   parameter int CNT_BIT        = 31,
   parameter int LANES          = 4,
   parameter int IN_DATA_WIDTH  = 8,
   parameter int OUT_LANE_WIDTH = 16,
   parameter int DWIDTH_1       = 32,
   parameter int DWIDTH_2       = 64,
   parameter int AWIDTH         = 8,
   parameter int MEM_SIZE       = 256,
   parameter int RD_LAT         = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start_run_i,
   input  logic [CNT_BIT-1:0]  run_count_i,
   input  logic [1:0]          mode_i,
   input  logic [AWIDTH-1:0]   src_base_i,
   input  logic [AWIDTH-1:0]   dst_base_i,
   input  logic [DWIDTH_1-1:0] q_b0_i,
   input  logic [DWIDTH_2-1:0] q_b1_i,
   output logic                idle_o,
   output logic                read_o,
   output logic                write_o,
   output logic                done_o,
   output logic [AWIDTH-1:0]   addr_b0_o,
   output logic                ce_b0_o,
   output logic                we_b0_o,
   output logic [DWIDTH_1-1:0] d_b0_o,
   output logic [AWIDTH-1:0]   addr_b1_o,
   output logic                ce_b1_o,
   output logic                we_b1_o,
   output logic [DWIDTH_2-1:0] d_b1_o
);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_run   = 2'd1;
   localparam logic [1:0] c_drain = 2'd2;
   localparam logic [1:0] c_done  = 2'd3;

   localparam logic [1:0] c_mode_sext = 2'd1;
   localparam logic [1:0] c_mode_acc  = 2'd2;

   logic [1:0]          r_state;
   logic [CNT_BIT-1:0]  r_count;
   logic [CNT_BIT-1:0]  r_rd_cnt;
   logic [1:0]          r_mode;
   logic [AWIDTH-1:0]   r_rd_ptr;
   logic [AWIDTH-1:0]   r_wr_ptr;
   logic [AWIDTH-1:0]   r_addr_b0;
   logic [AWIDTH-1:0]   r_addr_b1;
   logic [RD_LAT-1:0]   r_vld;
   logic                r_we_b1;
   logic [DWIDTH_2-1:0] r_d_b1;
   logic [DWIDTH_2-1:0] w_d_next;
   logic                w_start;
   logic                w_issue;
   logic                w_sample;
   logic                w_last;
   logic                w_unused;

   function automatic logic [AWIDTH-1:0] f_next_addr(input logic [AWIDTH-1:0] a);
      return (a == AWIDTH'(MEM_SIZE - 1)) ? '0 : a + AWIDTH'(1);
   endfunction

   assign w_start  = (r_state == c_idle) && start_run_i;
   assign w_issue  = (r_state == c_run);
   assign w_sample = r_vld[RD_LAT-1];
   assign w_last   = (r_rd_cnt == r_count - CNT_BIT'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= c_idle;
         r_count   <= '0;
         r_rd_cnt  <= '0;
         r_mode    <= '0;
         r_rd_ptr  <= '0;
         r_addr_b0 <= '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (start_run_i) begin
                  r_count  <= run_count_i;
                  r_mode   <= mode_i;
                  r_rd_ptr <= src_base_i;
                  r_rd_cnt <= '0;
                  r_state  <= (run_count_i == '0) ? c_done : c_run;
               end
            end
            c_run: begin
               r_addr_b0 <= r_rd_ptr;
               r_rd_ptr  <= f_next_addr(r_rd_ptr);
               r_rd_cnt  <= r_rd_cnt + CNT_BIT'(1);
               if (w_last) begin
                  r_state <= c_drain;
               end
            end
            c_drain: begin
               if (r_vld == '0) begin
                  r_state <= c_done;
               end
            end
            default: r_state <= c_idle;
         endcase
      end
   end

   // Read k lands in bit RD_LAT-1 on the edge where its BRAM0 data is valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vld     <= '0;
         r_we_b1   <= 1'b0;
         r_wr_ptr  <= '0;
         r_addr_b1 <= '0;
         r_d_b1    <= '0;
      end else begin
         r_vld   <= (r_vld << 1) | RD_LAT'(w_issue);
         r_we_b1 <= w_sample;
         if (w_start) begin
            r_wr_ptr <= dst_base_i;
         end else if (w_sample) begin
            r_addr_b1 <= r_wr_ptr;
            r_wr_ptr  <= f_next_addr(r_wr_ptr);
            r_d_b1    <= w_d_next;
         end
      end
   end

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         logic [IN_DATA_WIDTH-1:0]  w_in;
         logic [OUT_LANE_WIDTH-1:0] w_zext;
         logic [OUT_LANE_WIDTH-1:0] w_sext;
         logic [OUT_LANE_WIDTH-1:0] w_acc_next;
         logic [OUT_LANE_WIDTH-1:0] r_acc;
         logic [OUT_LANE_WIDTH:0]   w_sum;

         assign w_in   = q_b0_i[i*IN_DATA_WIDTH +: IN_DATA_WIDTH];
         assign w_zext = OUT_LANE_WIDTH'(w_in);
         assign w_sext = OUT_LANE_WIDTH'($signed(w_in));
         assign w_sum  = {1'b0, r_acc} + (OUT_LANE_WIDTH + 1)'(w_in);
`ifdef BRAM_ACC_SATURATE_EN
         assign w_acc_next = w_sum[OUT_LANE_WIDTH] ? '1 : w_sum[OUT_LANE_WIDTH-1:0];
`else
         logic w_unused_carry;
         assign w_unused_carry = w_sum[OUT_LANE_WIDTH];
         assign w_acc_next     = w_sum[OUT_LANE_WIDTH-1:0];
`endif
         assign w_d_next[i*OUT_LANE_WIDTH +: OUT_LANE_WIDTH] =
            (r_mode == c_mode_acc)  ? w_acc_next :
            (r_mode == c_mode_sext) ? w_sext     : w_zext;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_acc <= '0;
            end else if (w_start) begin
               r_acc <= '0;
            end else if (w_sample && (r_mode == c_mode_acc)) begin
               r_acc <= w_acc_next;
            end
         end
      end
   endgenerate

   assign w_unused  = ^q_b1_i;

   assign idle_o    = (r_state == c_idle);
   assign read_o    = w_issue;
   assign done_o    = (r_state == c_done);
   assign ce_b0_o   = w_issue;
   assign addr_b0_o = w_issue ? r_rd_ptr : r_addr_b0;
   assign we_b0_o   = 1'b0;
   assign d_b0_o    = '0;
   assign ce_b1_o   = r_we_b1;
   assign we_b1_o   = r_we_b1;
   assign write_o   = r_we_b1;
   assign addr_b1_o = r_addr_b1;
   assign d_b1_o    = r_d_b1;

endmodule
`default_nettype wire

// File: tb/tb_bram_lane_accessor.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_lane_accessor
// Purpose  : Scoreboard bench driving two accessors (RD_LAT 1 and 2) in step.
// Revision : 1.0 - initial bench
// ============================================================================
module tb_bram_lane_accessor;

   localparam int MEM = 256;

   typedef struct packed {
      int          cyc;
      logic [7:0]  addr;
      logic [63:0] data;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start_run_i;
   logic [30:0] run_count_i;
   logic [1:0]  mode_i;
   logic [7:0]  src_base_i;
   logic [7:0]  dst_base_i;
   logic [63:0] q_b1_i;

   logic        idle [2];
   logic        rd [2];
   logic        wr [2];
   logic        done [2];
   logic        ce_b0 [2];
   logic        we_b0 [2];
   logic        ce_b1 [2];
   logic        we_b1 [2];
   logic [7:0]  addr_b0 [2];
   logic [7:0]  addr_b1 [2];
   logic [31:0] d_b0 [2];
   logic [63:0] d_b1 [2];

   logic [31:0] mem0 [MEM];
   ev_t         rq [2][$];
   ev_t         wq [2][$];
   int          dq [2][$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   generate
      for (genvar d = 0; d < 2; d++) begin : g_dut
         logic [31:0] pipe [2];
         logic [31:0] q;

         always @(posedge clk) begin
            if (ce_b0[d]) pipe[0] <= mem0[addr_b0[d]];
            pipe[1] <= pipe[0];
         end
         assign q = pipe[d];

         bram_lane_accessor #(.RD_LAT(d + 1)) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .start_run_i (start_run_i),
            .run_count_i (run_count_i),
            .mode_i      (mode_i),
            .src_base_i  (src_base_i),
            .dst_base_i  (dst_base_i),
            .q_b0_i      (q),
            .q_b1_i      (q_b1_i),
            .idle_o      (idle[d]),
            .read_o      (rd[d]),
            .write_o     (wr[d]),
            .done_o      (done[d]),
            .addr_b0_o   (addr_b0[d]),
            .ce_b0_o     (ce_b0[d]),
            .we_b0_o     (we_b0[d]),
            .d_b0_o      (d_b0[d]),
            .addr_b1_o   (addr_b1[d]),
            .ce_b1_o     (ce_b1[d]),
            .we_b1_o     (we_b1[d]),
            .d_b1_o      (d_b1[d])
         );
      end
   endgenerate

   // Monitor: pops expected reads, writes and done pulses as the DUTs present them.
   always @(negedge clk) begin
      ev_t ev;
      int  dc;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (we_b0[d] !== 1'b0 || d_b0[d] !== '0 || ce_b1[d] !== we_b1[d] ||
             wr[d] !== we_b1[d] || rd[d] !== ce_b0[d]) begin
            errors++;
            $display("FAIL strobes dut%0d cyc %0d: we_b0=%b d_b0=%h ce_b1=%b we_b1=%b write=%b read=%b ce_b0=%b; want we_b0=0 d_b0=0 ce_b1=write=we_b1 read=ce_b0",
                     d, cyc, we_b0[d], d_b0[d], ce_b1[d], we_b1[d], wr[d], rd[d], ce_b0[d]);
         end
         if (ce_b0[d] === 1'b1) begin
            checks++;
            if (rq[d].size() == 0) begin
               errors++;
               $display("FAIL read dut%0d: unexpected read at cyc %0d addr %h, want none", d, cyc, addr_b0[d]);
            end else begin
               ev = rq[d].pop_front();
               if (ev.cyc != cyc || ev.addr !== addr_b0[d]) begin
                  errors++;
                  $display("FAIL read dut%0d: got cyc %0d addr %h, want cyc %0d addr %h", d, cyc, addr_b0[d], ev.cyc, ev.addr);
               end
            end
         end
         if (we_b1[d] === 1'b1) begin
            checks++;
            if (wq[d].size() == 0) begin
               errors++;
               $display("FAIL write dut%0d: unexpected write at cyc %0d addr %h data %h, want none", d, cyc, addr_b1[d], d_b1[d]);
            end else begin
               ev = wq[d].pop_front();
               if (ev.cyc != cyc || ev.addr !== addr_b1[d] || ev.data !== d_b1[d]) begin
                  errors++;
                  $display("FAIL write dut%0d: got cyc %0d addr %h data %h, want cyc %0d addr %h data %h",
                           d, cyc, addr_b1[d], d_b1[d], ev.cyc, ev.addr, ev.data);
               end
            end
         end
         if (done[d] === 1'b1) begin
            checks++;
            if (dq[d].size() == 0) begin
               errors++;
               $display("FAIL done dut%0d: unexpected done at cyc %0d, want none", d, cyc);
            end else begin
               dc = dq[d].pop_front();
               if (dc != cyc) begin
                  errors++;
                  $display("FAIL done dut%0d: got cyc %0d, want cyc %0d", d, cyc, dc);
               end
            end
         end
         if (rq[d].size() != 0 && rq[d][0].cyc <= cyc) begin
            checks++; errors++;
            $display("FAIL read dut%0d: none at cyc %0d, want addr %h", d, cyc, rq[d][0].addr);
            void'(rq[d].pop_front());
         end
         if (wq[d].size() != 0 && wq[d][0].cyc <= cyc) begin
            checks++; errors++;
            $display("FAIL write dut%0d: none at cyc %0d, want addr %h data %h", d, cyc, wq[d][0].addr, wq[d][0].data);
            void'(wq[d].pop_front());
         end
         if (dq[d].size() != 0 && dq[d][0] <= cyc) begin
            checks++; errors++;
            $display("FAIL done dut%0d: none at cyc %0d, want 1", d, cyc);
            void'(dq[d].pop_front());
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (idle[d] !== 1'b1 || rd[d] !== 1'b0 || wr[d] !== 1'b0 || done[d] !== 1'b0 ||
             ce_b0[d] !== 1'b0 || ce_b1[d] !== 1'b0 || we_b1[d] !== 1'b0 ||
             addr_b0[d] !== '0 || addr_b1[d] !== '0 || d_b1[d] !== '0) begin
            errors++;
            $display("FAIL %s dut%0d: idle=%b read=%b write=%b done=%b ce_b0=%b ce_b1=%b we_b1=%b a0=%h a1=%h d1=%h, want idle=1 and all else 0",
                     tag, d, idle[d], rd[d], wr[d], done[d], ce_b0[d], ce_b1[d], we_b1[d], addr_b0[d], addr_b1[d], d_b1[d]);
         end
      end
   endtask

   // Reference model: expected transactions straight from the lane rules.
   task automatic start_run(input int n, input int md, input int src, input int dst);
      int          s;
      int          v;
      int          acc [4];
      logic [31:0] w;
      logic [63:0] exp_d;
      ev_t         ev;
      @(posedge clk); #1;
      s = cyc;
      for (int l = 0; l < 4; l++) acc[l] = 0;
      for (int k = 0; k < n; k++) begin
         w     = mem0[(src + k) % MEM];
         exp_d = '0;
         for (int l = 0; l < 4; l++) begin
            v = int'(w[l*8 +: 8]);
            if (md == 1) begin
               if (v >= 128) v = v + 65536 - 256;
            end else if (md == 2) begin
`ifdef BRAM_ACC_SATURATE_EN
               acc[l] = (acc[l] + v > 65535) ? 65535 : acc[l] + v;
`else
               acc[l] = (acc[l] + v) % 65536;
`endif
               v = acc[l];
            end
            exp_d[l*16 +: 16] = 16'(v);
         end
         for (int d = 0; d < 2; d++) begin
            ev.cyc  = s + 1 + k;
            ev.addr = 8'((src + k) % MEM);
            ev.data = '0;
            rq[d].push_back(ev);
            ev.cyc  = s + 1 + k + (d + 1) + 1;
            ev.addr = 8'((dst + k) % MEM);
            ev.data = exp_d;
            wq[d].push_back(ev);
         end
      end
      for (int d = 0; d < 2; d++) dq[d].push_back((n == 0) ? s + 1 : s + 1 + n + (d + 1) + 1);
      start_run_i = 1'b1;
      run_count_i = 31'(n);
      mode_i      = 2'(md);
      src_base_i  = 8'(src);
      dst_base_i  = 8'(dst);
      @(posedge clk); #1;
      start_run_i = 1'b0;
      run_count_i = 31'($urandom_range(1, 300));
      mode_i      = 2'($urandom);
      src_base_i  = 8'($urandom);
      dst_base_i  = 8'($urandom);
   endtask

   task automatic finish_run(input int n, input string tag);
      repeat (n + 8) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (idle[d] !== 1'b1 || rq[d].size() != 0 || wq[d].size() != 0 || dq[d].size() != 0) begin
            errors++;
            $display("FAIL %s end dut%0d: idle=%b pending reads=%0d writes=%0d done=%0d, want idle=1 and 0 pending",
                     tag, d, idle[d], rq[d].size(), wq[d].size(), dq[d].size());
         end
      end
   endtask

   task automatic do_run(input int n, input int md, input int src, input int dst, input string tag);
      start_run(n, md, src, dst);
      finish_run(n, tag);
   endtask

   task automatic fill_const(input logic [31:0] val);
      for (int a = 0; a < MEM; a++) mem0[a] = val;
   endtask

   task automatic fill_random();
      for (int a = 0; a < MEM; a++) mem0[a] = $urandom;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n     = 1'b0;
      start_run_i = 1'b0;
      run_count_i = '0;
      mode_i      = '0;
      src_base_i  = '0;
      dst_base_i  = '0;
      q_b1_i      = '0;
      fill_const(32'h0);
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      fill_const(32'h01010101);
      do_run(256, 0, 0, 0, "mode0_full");
      fill_const(32'h80FF7F01);
      do_run(4, 1, 0, 0, "mode1_sext");
      fill_const(32'hFFFFFFFF);
      do_run(258, 2, 0, 0, "mode2_wrap");
      do_run(0, 0, 5, 9, "count0");

      fill_random();
      start_run(20, 0, 30, 60);
      repeat (2) @(posedge clk);
      #1;
      start_run_i = 1'b1;
      run_count_i = 31'd5;
      @(posedge clk); #1;
      start_run_i = 1'b0;
      finish_run(20, "start_in_run");

      do_run(4, 0, 8'hFE, 8'h10, "addr_wrap");

      start_run(256, 2, 0, 0);
      repeat (100) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      for (int d = 0; d < 2; d++) begin
         rq[d].delete();
         wq[d].delete();
         dq[d].delete();
      end
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (10) @(posedge clk);
      do_run(256, 2, 3, 200, "after_reset");

      for (int r = 0; r < 6; r++) begin
         fill_random();
         do_run($urandom_range(1, 40), $urandom_range(0, 3), $urandom_range(0, 255),
                $urandom_range(0, 255), "random");
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
